// File: rtl/gb_regbank.sv
// gb_regbank: ghostbus CSR bank and RAM with a pipelined host read path.
// Optional GB_REGBANK_ERRCNT_EN adds an unmapped-access counter at address NREG.
module gb_regbank #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32,
  parameter int unsigned NREG = 8,
  parameter logic [NREG-1:0] RO_MASK = '0,
  parameter logic [NREG*DW-1:0] CSR_INIT = '0,
  parameter int unsigned RAM_AW = 6,
  parameter int unsigned RAM_BASE = 'h100,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     gb_addr,
  input  logic [DW-1:0]     gb_dout,
  input  logic              gb_we,
  input  logic              gb_re,
  output logic [DW-1:0]     gb_din,
  output logic              gb_rvalid,
  output logic [NREG*DW-1:0] csr_q,
  output logic [NREG-1:0]   csr_wstb,
  input  logic [NREG*DW-1:0] sts_in,
  input  logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_q
);

  localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;
  localparam logic [AW-1:0] RAM_BASE_A = AW'(RAM_BASE);

  if (NREG < 1 || NREG > 64) begin : g_bad_nreg
    $error("gb_regbank: NREG must be 1..64");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("gb_regbank: RD_LAT must be 1..4");
  end
  if ((RAM_BASE % RAM_DEPTH) != 0) begin : g_bad_align
    $error("gb_regbank: RAM_BASE not aligned to RAM depth");
  end
  if (RAM_BASE < NREG + 1) begin : g_bad_base
    $error("gb_regbank: RAM_BASE overlaps CSR space");
  end

  logic              csr_hit;
  logic              ram_hit;
  logic [RAM_AW-1:0] hadr;

  assign csr_hit = gb_addr < AW'(NREG);
  assign ram_hit = gb_addr[AW-1:RAM_AW] == RAM_BASE_A[AW-1:RAM_AW];
  assign hadr    = gb_addr[RAM_AW-1:0];

  logic [DW-1:0]   csr_rd [NREG];
  logic [NREG-1:0] wstb_d;
  logic [NREG-1:0] wstb_q;
  logic            unused_sts;

  // RW slices ignore sts_in; RO slices have no storage at all.
  assign unused_sts = ^sts_in;

  for (genvar i = 0; i < NREG; i++) begin : g_csr
    if (RO_MASK[i]) begin : g_ro
      assign csr_q[i*DW +: DW] = '0;
      assign csr_rd[i]         = sts_in[i*DW +: DW];
      assign wstb_d[i]         = 1'b0;
    end else begin : g_rw
      logic          hit;
      logic [DW-1:0] reg_q;
      logic [DW-1:0] reg_d;

      assign hit = gb_we && (gb_addr == AW'(i));

      always_comb begin
        reg_d = reg_q;
        if (hit) reg_d = gb_dout;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) reg_q <= CSR_INIT[i*DW +: DW];
        else        reg_q <= reg_d;
      end

      assign csr_q[i*DW +: DW] = reg_q;
      assign csr_rd[i]         = reg_q;
      assign wstb_d[i]         = hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wstb_q <= '0;
    else        wstb_q <= wstb_d;
  end

  assign csr_wstb = wstb_q;

  logic [DW-1:0] mem_q [RAM_DEPTH];
  logic [DW-1:0] ram_rd_q;

  // Both ports read the pre-write word on a same-edge collision.
  always_ff @(posedge clk) begin
    if (gb_we && ram_hit) mem_q[hadr] <= gb_dout;
    ram_rd_q <= mem_q[ram_addr];
  end

  assign ram_q = ram_rd_q;

`ifdef GB_REGBANK_ERRCNT_EN
  logic        err_hit;
  logic        err_evt;
  logic        err_clr;
  logic [15:0] errcnt_q;
  logic [15:0] errcnt_d;

  assign err_hit = gb_addr == AW'(NREG);
  assign err_evt = (gb_we || gb_re) &&
                   !(csr_hit || ram_hit || err_hit);
  assign err_clr = gb_we && err_hit;

  always_comb begin
    errcnt_d = errcnt_q;
    if (err_clr)
      errcnt_d = {15'd0, err_evt};
    else if (err_evt && errcnt_q != 16'hffff)
      errcnt_d = errcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) errcnt_q <= '0;
    else        errcnt_q <= errcnt_d;
  end
`endif

  logic [DW-1:0] csr_sel;
  logic [DW-1:0] rd_data;

  always_comb begin
    csr_sel = '0;
    for (int i = 0; i < NREG; i++) begin
      if (gb_addr == AW'(i)) csr_sel = csr_rd[i];
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      csr_hit: rd_data = csr_sel;
      ram_hit: rd_data = mem_q[hadr];
`ifdef GB_REGBANK_ERRCNT_EN
      err_hit: rd_data = DW'(errcnt_q);
`endif
      default: rd_data = '0;
    endcase
  end

  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] pv_d;
  logic [DW-1:0]     pd_q [RD_LAT];
  logic [DW-1:0]     pd_d [RD_LAT];

  // Data stages only advance with a valid token, so gb_din holds.
  always_comb begin
    pv_d    = '0;
    pd_d    = pd_q;
    pv_d[0] = gb_re;
    if (gb_re) pd_d[0] = rd_data;
    for (int k = 1; k < RD_LAT; k++) begin
      pv_d[k] = pv_q[k-1];
      if (pv_q[k-1]) pd_d[k] = pd_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int k = 0; k < RD_LAT; k++) pd_q[k] <= '0;
    end else begin
      pv_q <= pv_d;
      pd_q <= pd_d;
    end
  end

  assign gb_rvalid = pv_q[RD_LAT-1];
  assign gb_din    = pd_q[RD_LAT-1];

endmodule

// File: tb/tb_gb_regbank.sv
// tb_gb_regbank: table vectors, directed corner cases and random traffic
// checked against an address-map level model of gb_regbank.
module tb_gb_regbank;

  localparam int RD_LAT = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [11:0]  gb_addr = '0;
  logic [31:0]  gb_dout = '0;
  logic         gb_we = 1'b0;
  logic         gb_re = 1'b0;
  logic [31:0]  gb_din;
  logic         gb_rvalid;
  logic [127:0] csr_q;
  logic [3:0]   csr_wstb;
  logic [127:0] sts_in = '0;
  logic [5:0]   ram_addr = '0;
  logic [31:0]  ram_q;

  gb_regbank #(
    .AW(12), .DW(32), .NREG(4),
    .RO_MASK(4'b0010),
    .CSR_INIT({32'h4, 32'h3, 32'h2, 32'h1}),
    .RAM_AW(6), .RAM_BASE('h100), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .gb_addr(gb_addr), .gb_dout(gb_dout),
    .gb_we(gb_we), .gb_re(gb_re),
    .gb_din(gb_din), .gb_rvalid(gb_rvalid),
    .csr_q(csr_q), .csr_wstb(csr_wstb),
    .sts_in(sts_in), .ram_addr(ram_addr), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  int cyc = 0;

  function automatic void chk(string nm, logic [127:0] act,
                              logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;

  logic [31:0] m_csr [4];
  logic [31:0] m_ram [64];
  bit          m_ram_v [64];
  logic [15:0] m_err;
  rsp_t        m_q [$];
  logic [31:0] exp_din;
  logic        exp_rv;
  logic [3:0]  exp_wstb;
  logic [31:0] exp_ramq;
  bit          ramq_known = 0;

  bit          rec_en = 0;
  logic [31:0] rec_d [$];
  int          rec_c [$];

  function automatic void model_reset();
    m_csr[0] = 32'h1; m_csr[1] = 32'h0;
    m_csr[2] = 32'h3; m_csr[3] = 32'h4;
    m_err = '0;
    m_q.delete();
    exp_din = '0; exp_rv = 1'b0; exp_wstb = '0;
  endfunction

  function automatic bit is_unmapped(logic [11:0] a);
    bit mapped;
    mapped = (a < 12'd4) || (a[11:6] == 6'h04);
`ifdef GB_REGBANK_ERRCNT_EN
    mapped = mapped || (a == 12'd4);
`endif
    return !mapped;
  endfunction

  function automatic logic [31:0] mread(logic [11:0] a);
    if (a < 12'd4) return (a == 12'd1) ? sts_in[63:32] : m_csr[a[1:0]];
    if (a[11:6] == 6'h04) return m_ram[a[5:0]];
`ifdef GB_REGBANK_ERRCNT_EN
    if (a == 12'd4) return {16'h0, m_err};
`endif
    return 32'h0;
  endfunction

  task automatic tick();
    bit evt;
    @(posedge clk);
    cyc++;
    ramq_known = m_ram_v[ram_addr];
    exp_ramq = m_ram[ram_addr];
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_wstb = '0;
      if (gb_re) m_q.push_back('{cyc + RD_LAT - 1, mread(gb_addr)});
      evt = (gb_we || gb_re) && is_unmapped(gb_addr);
`ifdef GB_REGBANK_ERRCNT_EN
      if (gb_we && gb_addr == 12'd4) m_err = evt ? 16'd1 : 16'd0;
      else if (evt && m_err != 16'hffff) m_err = m_err + 16'd1;
`endif
      if (gb_we && gb_addr < 12'd4 && gb_addr != 12'd1) begin
        m_csr[gb_addr[1:0]] = gb_dout;
        exp_wstb[gb_addr[1:0]] = 1'b1;
      end
      if (gb_we && gb_addr[11:6] == 6'h04) begin
        m_ram[gb_addr[5:0]] = gb_dout;
        m_ram_v[gb_addr[5:0]] = 1'b1;
      end
      exp_rv = 1'b0;
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        exp_rv = 1'b1;
        exp_din = m_q[0].d;
        void'(m_q.pop_front());
      end
    end
    #1;
    chk("rvalid", gb_rvalid, exp_rv);
    chk("din", gb_din, exp_din);
    chk("csr_q", csr_q, {m_csr[3], m_csr[2], 32'h0, m_csr[0]});
    chk("wstb", csr_wstb, exp_wstb);
    if (ramq_known) chk("ram_q", ram_q, exp_ramq);
    if (rec_en && gb_rvalid) begin
      rec_d.push_back(gb_din);
      rec_c.push_back(cyc);
    end
  endtask

  task automatic rd(logic [11:0] a, logic [31:0] exp, string nm);
    gb_re = 1'b1; gb_addr = a;
    tick();
    gb_re = 1'b0;
    repeat (RD_LAT - 1) tick();
    chk({nm, "_rv"}, gb_rvalid, 1'b1);
    chk(nm, gb_din, exp);
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_wstb;
  } vec_t;

  vec_t tbl [$];

  initial begin
    int k;
    logic [15:0] ecnt_exp;

    tbl.push_back('{1, 0, 12'h002, 32'hdeadbeef, 32'h0, 4'b0100});
    tbl.push_back('{0, 1, 12'h002, 32'h0, 32'hdeadbeef, 4'b0});
    tbl.push_back('{1, 0, 12'h001, 32'h1, 32'h0, 4'b0000});
    tbl.push_back('{0, 1, 12'h001, 32'h0, 32'h0000cafe, 4'b0});
    tbl.push_back('{0, 1, 12'h000, 32'h0, 32'h1, 4'b0});
    tbl.push_back('{0, 1, 12'h003, 32'h0, 32'h4, 4'b0});
    tbl.push_back('{1, 0, 12'h003, 32'h77, 32'h0, 4'b1000});
    tbl.push_back('{1, 0, 12'h100, 32'h10, 32'h0, 4'b0});
    tbl.push_back('{1, 0, 12'h101, 32'h11, 32'h0, 4'b0});
    tbl.push_back('{1, 0, 12'h102, 32'h12, 32'h0, 4'b0});
    tbl.push_back('{1, 0, 12'h103, 32'h13, 32'h0, 4'b0});
    tbl.push_back('{0, 1, 12'h102, 32'h0, 32'h12, 4'b0});
    tbl.push_back('{0, 1, 12'h0ff, 32'h0, 32'h0, 4'b0});
    tbl.push_back('{1, 0, 12'h200, 32'h9, 32'h0, 4'b0});
`ifdef GB_REGBANK_ERRCNT_EN
    tbl.push_back('{0, 1, 12'h004, 32'h0, 32'h2, 4'b0});
`else
    tbl.push_back('{0, 1, 12'h004, 32'h0, 32'h0, 4'b0});
`endif
    tbl.push_back('{0, 1, 12'h003, 32'h0, 32'h77, 4'b0});

    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_csr", csr_q, {32'h4, 32'h3, 32'h0, 32'h1});
    chk("rst_rv", gb_rvalid, 1'b0);
    chk("rst_din", gb_din, 32'h0);
    chk("rst_wstb", csr_wstb, 4'b0);
    sts_in[63:32] = 32'h0000cafe;

    for (int i = 0; i < 64; i++) begin
      gb_we = 1'b1; gb_addr = 12'h100 + 12'(i);
      gb_dout = 32'ha000 + 32'(i);
      tick();
    end
    gb_we = 1'b0;

    foreach (tbl[i]) begin
      gb_we = tbl[i].we; gb_re = tbl[i].re;
      gb_addr = tbl[i].addr; gb_dout = tbl[i].wd;
      tick();
      gb_we = 1'b0; gb_re = 1'b0;
      if (tbl[i].we) chk("tbl_wstb", csr_wstb, tbl[i].exp_wstb);
      if (tbl[i].re) begin
        repeat (RD_LAT - 1) tick();
        chk("tbl_rv", gb_rvalid, 1'b1);
        chk("tbl_rd", gb_din, tbl[i].exp_rd);
      end
    end

    rec_en = 1;
    for (int i = 0; i < 4; i++) begin
      gb_re = 1'b1; gb_addr = 12'h100 + 12'(i);
      tick();
    end
    gb_re = 1'b0;
    repeat (RD_LAT + 1) tick();
    rec_en = 0;
    chk("stream_n", rec_d.size(), 4);
    for (int i = 0; i < rec_d.size() && i < 4; i++) begin
      chk("stream_d", rec_d[i], 32'h10 + 32'(i));
      chk("stream_gap", rec_c[i] - rec_c[0], i);
    end

    ram_addr = 6'd2;
    tick();
    chk("fabric", ram_q, 32'h12);

    gb_we = 1'b1; gb_re = 1'b1;
    gb_addr = 12'h101; gb_dout = 32'h55;
    ram_addr = 6'd1;
    tick();
    chk("coll_fab", ram_q, 32'h11);
    gb_we = 1'b0; gb_re = 1'b0;
    repeat (RD_LAT - 1) tick();
    chk("coll_old", gb_din, 32'h11);
    rd(12'h101, 32'h55, "coll_new");

    gb_re = 1'b1; gb_addr = 12'h100;
    repeat (2) tick();
    gb_re = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_rv", gb_rvalid, 1'b0);
    chk("mid_rst_din", gb_din, 32'h0);
    chk("mid_rst_csr", csr_q, {32'h4, 32'h3, 32'h0, 32'h1});
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      chk("rst_norv", gb_rvalid, 1'b0);
    end

`ifdef GB_REGBANK_ERRCNT_EN
    gb_re = 1'b1; gb_addr = 12'h0ff;
    repeat (3) tick();
    gb_we = 1'b1; gb_addr = 12'h200;
    tick();
    gb_we = 1'b0; gb_re = 1'b0;
    repeat (RD_LAT) tick();
    rd(12'h004, 32'h4, "err_cnt4");
    gb_we = 1'b1; gb_addr = 12'h004; gb_dout = 32'hffff;
    tick();
    gb_we = 1'b0;
    rd(12'h004, 32'h0, "err_clr");
`endif

    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3, 4, 5: gb_addr = 12'(k);
        6:                gb_addr = 12'h0ff;
        7, 8:             gb_addr = 12'h100 + 12'($urandom_range(0, 63));
        default:          gb_addr = 12'($urandom);
      endcase
      gb_we = 1'($urandom);
      gb_re = 1'($urandom);
      gb_dout = $urandom;
      sts_in = {$urandom, $urandom, $urandom, $urandom};
      ram_addr = 6'($urandom);
      tick();
    end
    gb_we = 1'b0; gb_re = 1'b0;
    repeat (RD_LAT) tick();

`ifdef GB_REGBANK_ERRCNT_EN
    gb_re = 1'b1; gb_addr = 12'h0ff;
    repeat (65540) tick();
    gb_re = 1'b0;
    repeat (RD_LAT) tick();
    ecnt_exp = 16'hffff;
    rd(12'h004, {16'h0, ecnt_exp}, "err_sat");
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
